// File: rtl/div47_pkg.sv
// Shared constants and types for the divide-by-47 reconstruction datapath.
package div47_pkg;

    localparam int DIVISOR = 47;
    localparam int XW      = 60;
    localparam int QW      = 55;
    localparam int DW      = 6;
    localparam int NDIG    = XW / DW;
    localparam int CW      = 4;

    typedef logic [DW-1:0]   digit_t;
    typedef logic [2*DW-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divisor and last digit index in the widths they are compared at.
    localparam digit_t         DIV_D    = digit_t'(DIVISOR);
    localparam logic [CW-1:0]  LAST_DIG = CW'(NDIG - 1);

endpackage

// File: rtl/div47_digit_mac.sv
// One digit step of the reconstruction: {cout, sout} = d*47 + cin.
// The multiply by 47 is a fixed shift-add tree (32+8+4+2+1), no multiplier.
module div47_digit_mac
    import div47_pkg::*;
(
    input  digit_t d,
    input  digit_t cin,
    output digit_t cout,
    output digit_t sout
);

    prod_t dx;
    prod_t s;

    assign dx = prod_t'(d);
    // Worst case 63*47 + 63 = 3024 still fits the 12-bit product.
    assign s  = (dx << 5) + (dx << 3) + (dx << 2) + (dx << 1) + dx + prod_t'(cin);
    assign {cout, sout} = s;

endmodule

// File: rtl/div47_recon_serial.sv
// Digit-serial rebuild of x = q*47 + r, six quotient bits per cycle,
// with valid/ready on both sides and range/overflow flags.
module div47_recon_serial
    import div47_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] q,
    input  logic [DW-1:0] r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] x,
    output logic          err_rem,
    output logic          ovf
);

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [XW-1:0]  qreg_q;
    logic [XW-1:0]  xreg_q;
    digit_t         carry_q;
    logic           err_q;
    logic           ovf_q;

    digit_t         mac_cout;
    digit_t         mac_sout;
    logic           accept;
    logic           last_dig;

    div47_digit_mac u_mac (
        .d    (qreg_q[DW-1:0]),
        .cin  (carry_q),
        .cout (mac_cout),
        .sout (mac_sout)
    );

    assign accept   = in_valid && in_ready;
    assign last_dig = (cnt_q == LAST_DIG);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode; handshakes come from state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_dig) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, shift one digit per RUN cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            qreg_q  <= '0;
            xreg_q  <= '0;
            carry_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        qreg_q  <= XW'(q);
                        carry_q <= r;
                        err_q   <= (r >= DIV_D);
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    // Low digit result enters at the top; after ten shifts
                    // digit 0 lands in x[5:0].
                    xreg_q  <= {mac_sout, xreg_q[XW-1:DW]};
                    qreg_q  <= qreg_q >> DW;
                    carry_q <= mac_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_dig) begin
                        ovf_q <= (mac_cout != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x       = xreg_q;
    assign err_rem = err_q;
    assign ovf     = ovf_q;

endmodule
